sync_updown_counter: RTL and testbench

//   Fully synchronous, enable-gated modulo counter with load, start/stop and one-shot control.
//   It is the single-clock counterpart to the team's T-flip-flop ripple counters: every bit changes on clk.

---
 rtl/sync_updown_counter.sv | 104 ++++++++++
 tb/tb_sync_updown_counter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/sync_updown_counter.sv
// Single-clock modulo counter (0..MAX) with load, start/stop, one-shot hold and tc pulse.
// Optional macro COUNTER_DIR_EN adds the up_dn direction input.
module sync_updown_counter #(
    parameter int WIDTH = 4,
    parameter int MAX   = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             stop,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef COUNTER_DIR_EN
    input  logic             up_dn,
`endif
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] L_MAX  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] L_ZERO = '0;
    localparam logic [WIDTH-1:0] L_ONE  = WIDTH'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_mode, w_mode_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt, w_q_step;
    logic             r_tc, w_tc_nxt;
    logic             w_up, w_wrap, w_step;

    function automatic logic [WIDTH-1:0] clamp(input logic [WIDTH-1:0] v);
        return (v > L_MAX) ? L_MAX : v;
    endfunction

`ifdef COUNTER_DIR_EN
    assign w_up = up_dn;
`else
    assign w_up = 1'b1;
`endif

    // Wrap is decided per step from the current direction, so up_dn may change at any time.
    always_comb begin
        w_wrap   = 1'b0;
        w_q_step = r_q;
        if (w_up) begin
            w_wrap   = (r_q == L_MAX);
            w_q_step = w_wrap ? L_ZERO : r_q + L_ONE;
        end else begin
            w_wrap   = (r_q == L_ZERO);
            w_q_step = w_wrap ? L_MAX : r_q - L_ONE;
        end
    end

    assign w_step = (r_state == S_RUN) && en && !load && !stop;

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_q_nxt     = r_q;
        w_tc_nxt    = 1'b0;
        if (load) begin
            w_q_nxt = clamp(load_val);
        end else if (w_step) begin
            w_q_nxt  = w_q_step;
            w_tc_nxt = w_wrap;
            if (w_wrap && r_mode)
                w_state_nxt = S_HOLD;
        end
        // Stop beats start; start from RUN neither restarts nor re-latches the mode.
        if (stop) begin
            w_state_nxt = S_IDLE;
        end else if (start && (r_state != S_RUN)) begin
            w_state_nxt = S_RUN;
            w_mode_nxt  = oneshot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_mode  <= 1'b0;
            r_q     <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_q     <= w_q_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    assign q     = r_q;
    assign count = r_q;
    assign tc    = r_tc;
    assign busy  = (r_state == S_RUN);
    assign done  = (r_state == S_HOLD);

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench for sync_updown_counter with WIDTH=4, MAX=9.
module tb_sync_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, start, stop, oneshot, load;
    logic [3:0] load_val;
`ifdef COUNTER_DIR_EN
    logic       up_dn;
`endif
    logic [3:0] q, count;
    logic       tc, busy, done;

    int checks   = 0;
    int failures = 0;

    sync_updown_counter #(.WIDTH(4), .MAX(9)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .oneshot(oneshot), .load(load), .load_val(load_val),
`ifdef COUNTER_DIR_EN
        .up_dn(up_dn),
`endif
        .q(q), .count(count), .tc(tc), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int eq, input int etc,
                             input int ebusy, input int edone);
        check({tag, ".q"}, int'(q), eq);
        check({tag, ".count"}, int'(count), eq);
        check({tag, ".tc"}, int'(tc), etc);
        check({tag, ".busy"}, int'(busy), ebusy);
        check({tag, ".done"}, int'(done), edone);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_q  [12];
        int exp_tc [12];
        exp_q  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        exp_tc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};

        rst = 1'b1; en = 1'b1; start = 1'b1; stop = 1'b0;
        oneshot = 1'b0; load = 1'b0; load_val = 4'd0;
`ifdef COUNTER_DIR_EN
        up_dn = 1'b1;
`endif
        // 1: reset dominates en and start
        tick(); check_all("rst1", 0, 0, 0, 0);
        tick(); check_all("rst2", 0, 0, 0, 0);

        // 2: free-run through the MAX=9 wrap
        rst = 1'b0; en = 1'b0; start = 1'b1; oneshot = 1'b0;
        tick(); check_all("fr_start", 0, 0, 1, 0);
        start = 1'b0; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check_all($sformatf("fr_step%0d", i), exp_q[i], exp_tc[i], 1, 0);
        end

        // stop with en=1 freezes q
        stop = 1'b1;
        tick(); check_all("fr_stop", 2, 0, 0, 0);
        stop = 1'b0;

        // 3: one-shot, with an ignored start(oneshot=0) while running
        start = 1'b1; oneshot = 1'b1; en = 1'b0;
        tick(); check_all("os_start", 2, 0, 1, 0);
        start = 1'b0; en = 1'b1;
        for (int v = 3; v <= 9; v++) begin
            if (v == 5) begin start = 1'b1; oneshot = 1'b0; end
            tick(); check_all($sformatf("os_q%0d", v), v, 0, 1, 0);
            start = 1'b0;
        end
        tick(); check_all("os_wrap", 0, 1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            tick(); check_all($sformatf("os_hold%0d", i), 0, 0, 0, 1);
        end

        // 4: load clamp while running, then load+stop
        start = 1'b1; oneshot = 1'b0; en = 1'b0;
        tick(); check_all("ld_start", 0, 0, 1, 0);
        start = 1'b0; en = 1'b1;
        tick(); tick(); tick(); check_all("ld_q3", 3, 0, 1, 0);
        load = 1'b1; load_val = 4'd15;
        tick(); check_all("ld_clamp", 9, 0, 1, 0);
        load = 1'b0;
        tick(); check_all("ld_wrap", 0, 1, 1, 0);
        en = 1'b0;
        tick(); check_all("tc_noext", 0, 0, 1, 0);
        load = 1'b1; stop = 1'b1; load_val = 4'd4;
        tick(); check_all("ld_stop", 4, 0, 0, 0);
        load = 1'b0; stop = 1'b0;

        // 5: stop at 5, resume, reset mid-count
        start = 1'b1;
        tick(); check_all("ss_start", 4, 0, 1, 0);
        start = 1'b0; en = 1'b1;
        tick(); check_all("ss_q5", 5, 0, 1, 0);
        stop = 1'b1;
        tick(); check_all("ss_stop", 5, 0, 0, 0);
        stop = 1'b0;
        tick(); check_all("ss_frozen", 5, 0, 0, 0);
        start = 1'b1;
        tick(); check_all("ss_restart", 5, 0, 1, 0);
        start = 1'b0;
        tick(); check_all("ss_q6", 6, 0, 1, 0);
        tick(); check_all("ss_q7", 7, 0, 1, 0);
        rst = 1'b1;
        tick(); check_all("ss_rst", 0, 0, 0, 0);
        rst = 1'b0; start = 1'b1; stop = 1'b1;
        tick(); check_all("stop_beats_start", 0, 0, 0, 0);
        start = 1'b0; stop = 1'b0; en = 1'b0;

`ifdef COUNTER_DIR_EN
        // 6: down count through 0 -> MAX, then up wrap from MAX
        load = 1'b1; load_val = 4'd2;
        tick(); check_all("dn_load", 2, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        tick(); check_all("dn_start", 2, 0, 1, 0);
        start = 1'b0; en = 1'b1; up_dn = 1'b0;
        tick(); check_all("dn_q1", 1, 0, 1, 0);
        tick(); check_all("dn_q0", 0, 0, 1, 0);
        tick(); check_all("dn_wrap", 9, 1, 1, 0);
        up_dn = 1'b1;
        tick(); check_all("up_wrap", 0, 1, 1, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
